// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response and memory-side R/W signals of the load/store controller.
interface mem_access_ctrl_if #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 32
);
    logic                 req;
    logic                 we;
    logic [1:0]           size;
    logic                 sign_ext;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] wdata;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [DataWidth-1:0] rdata;
    logic [AddrWidth-1:0] mem_Addr;
    logic                 mem_R;
    logic                 mem_W;
    logic [DataWidth-1:0] mem_W_data;
    logic [DataWidth-1:0] mem_R_data;

    // Controller view.
    modport slave (
        input  req, we, size, sign_ext, addr, wdata, mem_R_data,
        output busy, done, err, rdata, mem_Addr, mem_R, mem_W, mem_W_data
    );

    // CPU plus memory environment view.
    modport master (
        output req, we, size, sign_ext, addr, wdata, mem_R_data,
        input  busy, done, err, rdata, mem_Addr, mem_R, mem_W, mem_W_data
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer for a single-port word memory: word R/W, sub-word
// read-modify-write stores, lane extraction with sign/zero extension.
module mem_access_ctrl #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 32
) (
    input  logic               CLK,
    input  logic               RST_n,
    mem_access_ctrl_if.slave   bus
);

    localparam int unsigned WordW = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        WR     = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        RESP   = 3'd5,
        ERR    = 3'd6
    } state_e;

    state_e               state_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;
    logic                 mem_R_q;
    logic                 mem_W_q;
    logic [DataWidth-1:0] rdata_q;
    logic [AddrWidth-1:0] mem_Addr_q;
    logic [DataWidth-1:0] mem_W_data_q;
    logic [1:0]           size_q;
    logic                 sign_q;
    logic [1:0]           off_q;
    logic [15:0]          wdata_q;

    logic                 illegal_c;

    // Select the addressed lane and extend it to a full word.
    function automatic logic [WordW-1:0] extract(input logic [WordW-1:0] w,
                                                 input logic [1:0] sz,
                                                 input logic [1:0] off,
                                                 input logic sx);
        logic [7:0]       b;
        logic [15:0]      h;
        logic [WordW-1:0] r;
        b = 8'(w >> {off, 3'b000});
        h = off[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   r = {{24{sx & b[7]}}, b};
            2'b01:   r = {{16{sx & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Replace only the addressed byte/halfword lane of the word read back.
    function automatic logic [WordW-1:0] merge(input logic [WordW-1:0] w,
                                               input logic [1:0] sz,
                                               input logic [1:0] off,
                                               input logic [15:0] wd);
        logic [WordW-1:0] mask;
        logic [WordW-1:0] data;
        if (sz == 2'b00) begin
            mask = 32'h0000_00FF << {off, 3'b000};
            data = {4{wd[7:0]}};
        end else begin
            mask = off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            data = {2{wd}};
        end
        return (w & ~mask) | (data & mask);
    endfunction

    always_comb begin
        illegal_c = 1'b0;
        case (bus.size)
            2'b01:   illegal_c = bus.addr[0];
            2'b10:   illegal_c = (bus.addr[1:0] != 2'b00);
            2'b11:   illegal_c = 1'b1;
            default: illegal_c = 1'b0;
        endcase
    end

    // State and every output are registered together; outputs follow the state entered.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            mem_R_q      <= 1'b0;
            mem_W_q      <= 1'b0;
            rdata_q      <= '0;
            mem_Addr_q   <= '0;
            mem_W_data_q <= '0;
            size_q       <= 2'b00;
            sign_q       <= 1'b0;
            off_q        <= 2'b00;
            wdata_q      <= 16'h0000;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        size_q  <= bus.size;
                        sign_q  <= bus.sign_ext;
                        off_q   <= bus.addr[1:0];
                        wdata_q <= bus.wdata[15:0];
                        busy_q  <= 1'b1;
                        if (illegal_c) begin
                            state_q <= ERR;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            mem_Addr_q <= {bus.addr[AddrWidth-1:2], 2'b00};
                            if (!bus.we) begin
                                state_q <= RD;
                                mem_R_q <= 1'b1;
                            end else if (bus.size == 2'b10) begin
                                state_q      <= WR;
                                mem_W_q      <= 1'b1;
                                mem_W_data_q <= bus.wdata;
                            end else begin
                                state_q <= RMW_RD;
                                mem_R_q <= 1'b1;
                            end
                        end
                    end
                end
                RD: begin
                    rdata_q <= extract(bus.mem_R_data, size_q, off_q, sign_q);
                    mem_R_q <= 1'b0;
                    state_q <= RESP;
                    done_q  <= 1'b1;
                end
                WR: begin
                    mem_W_q <= 1'b0;
                    state_q <= RESP;
                    done_q  <= 1'b1;
                end
                RMW_RD: begin
                    mem_W_data_q <= merge(bus.mem_R_data, size_q, off_q, wdata_q);
                    mem_R_q      <= 1'b0;
                    mem_W_q      <= 1'b1;
                    state_q      <= RMW_WR;
                end
                RMW_WR: begin
                    mem_W_q <= 1'b0;
                    state_q <= RESP;
                    done_q  <= 1'b1;
                end
                RESP, ERR: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    mem_R_q <= 1'b0;
                    mem_W_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.rdata      = rdata_q;
    assign bus.mem_Addr   = mem_Addr_q;
    assign bus.mem_R      = mem_R_q;
    assign bus.mem_W      = mem_W_q;
    assign bus.mem_W_data = mem_W_data_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a 32-word behavioural memory.
module tb_mem_access_ctrl;

    logic CLK;
    logic RST_n;
    int   checks;
    int   failures;

    mem_access_ctrl_if bus ();

    mem_access_ctrl dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [31:0] mem [0:31];
    int          mem_w_cnt;
    int          mem_r_cnt;
    logic        both_hi;
    logic [31:0] last_w_addr;

    assign bus.mem_R_data = mem[bus.mem_Addr[6:2]];

    always @(posedge CLK) begin
        if (bus.mem_W) begin
            mem[bus.mem_Addr[6:2]] <= bus.mem_W_data;
            last_w_addr = bus.mem_Addr;
            mem_w_cnt++;
        end
        if (bus.mem_R) mem_r_cnt++;
        if (bus.mem_R && bus.mem_W) both_hi = 1'b1;
    end

    // Issue one request; report cycles to done (-1 if never), err and rdata at done.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic e, output logic [31:0] rd);
        @(negedge CLK);
        mem_w_cnt = 0;
        mem_r_cnt = 0;
        bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sign_ext = sx;
        bus.addr = a; bus.wdata = wd;
        @(posedge CLK); #1;
        bus.req = 1'b0;
        lat = -1; e = 1'b0; rd = 32'h0;
        for (int k = 1; k <= 12; k++) begin
            if (bus.done) begin
                lat = k; e = bus.err; rd = bus.rdata;
                break;
            end
            @(posedge CLK); #1;
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset;
        RST_n = 1'b0;
        #12;
        checks++;
        if ({bus.busy, bus.done, bus.err, bus.mem_R, bus.mem_W} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000", {bus.busy, bus.done, bus.err, bus.mem_R, bus.mem_W});
        end
        checks++;
        if (bus.rdata !== 32'h0 || bus.mem_Addr !== 32'h0 || bus.mem_W_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_data rdata=%h addr=%h wdata=%h exp=0", bus.rdata, bus.mem_Addr, bus.mem_W_data);
        end
        @(negedge CLK);
        RST_n = 1'b1;
    endtask

    task automatic test_word_store_load;
        int lat; logic e; logic [31:0] rd;
        do_req(1'b1, 2'b10, 1'b0, 32'h3C, 32'h0000_0007, lat, e, rd);
        checks++;
        if (lat !== 2 || e !== 1'b0) begin
            failures++; $display("FAIL wstore_lat lat=%0d err=%b exp=2/0", lat, e);
        end
        checks++;
        if (mem_w_cnt !== 1 || last_w_addr !== 32'h3C || mem_r_cnt !== 0) begin
            failures++; $display("FAIL wstore_mem wcnt=%0d addr=%h rcnt=%0d exp=1/3c/0", mem_w_cnt, last_w_addr, mem_r_cnt);
        end
        checks++;
        if (bus.rdata !== 32'h0) begin
            failures++; $display("FAIL wstore_rdata got=%h exp=00000000", bus.rdata);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, lat, e, rd);
        checks++;
        if (lat !== 2 || e !== 1'b0 || rd !== 32'h0000_0007) begin
            failures++; $display("FAIL wload lat=%0d err=%b rdata=%h exp=2/0/00000007", lat, e, rd);
        end
    endtask

    task automatic test_byte_rmw;
        int lat; logic e; logic [31:0] rd;
        mem[15] = 32'h1122_3344;
        do_req(1'b1, 2'b00, 1'b0, 32'h3D, 32'hFFFF_FFAB, lat, e, rd);
        checks++;
        if (lat !== 3 || e !== 1'b0) begin
            failures++; $display("FAIL rmw_lat lat=%0d err=%b exp=3/0", lat, e);
        end
        checks++;
        if (mem[15] !== 32'h1122_AB44 || mem_r_cnt !== 1 || mem_w_cnt !== 1) begin
            failures++; $display("FAIL rmw_byte mem=%h rcnt=%0d wcnt=%0d exp=1122ab44/1/1", mem[15], mem_r_cnt, mem_w_cnt);
        end
        do_req(1'b1, 2'b01, 1'b0, 32'h3E, 32'hDEAD_BEEF, lat, e, rd);
        checks++;
        if (lat !== 3 || mem[15] !== 32'hBEEF_AB44) begin
            failures++; $display("FAIL rmw_half lat=%0d mem=%h exp=3/beefab44", lat, mem[15]);
        end
    endtask

    task automatic test_loads;
        int lat; logic e; logic [31:0] rd;
        mem[16] = 32'h80FF_7F01;
        do_req(1'b0, 2'b00, 1'b1, 32'h42, 32'h0, lat, e, rd);
        checks++;
        if (rd !== 32'hFFFF_FFFF || lat !== 2) begin
            failures++; $display("FAIL lb_sx42 got=%h lat=%0d exp=ffffffff/2", rd, lat);
        end
        do_req(1'b0, 2'b00, 1'b0, 32'h43, 32'h0, lat, e, rd);
        checks++;
        if (rd !== 32'h0000_0080) begin
            failures++; $display("FAIL lbu_43 got=%h exp=00000080", rd);
        end
        do_req(1'b0, 2'b00, 1'b1, 32'h40, 32'h0, lat, e, rd);
        checks++;
        if (rd !== 32'h0000_0001) begin
            failures++; $display("FAIL lb_sx40 got=%h exp=00000001", rd);
        end
        do_req(1'b0, 2'b01, 1'b1, 32'h40, 32'h0, lat, e, rd);
        checks++;
        if (rd !== 32'h0000_7F01) begin
            failures++; $display("FAIL lh_sx40 got=%h exp=00007f01", rd);
        end
        do_req(1'b0, 2'b01, 1'b1, 32'h42, 32'h0, lat, e, rd);
        checks++;
        if (rd !== 32'hFFFF_80FF) begin
            failures++; $display("FAIL lh_sx42 got=%h exp=ffff80ff", rd);
        end
        do_req(1'b0, 2'b01, 1'b0, 32'h42, 32'h0, lat, e, rd);
        checks++;
        if (rd !== 32'h0000_80FF || bus.rdata !== 32'h0000_80FF) begin
            failures++; $display("FAIL lhu_42 got=%h held=%h exp=000080ff", rd, bus.rdata);
        end
    endtask

    task automatic test_misaligned;
        int lat; logic e; logic [31:0] rd;
        do_req(1'b0, 2'b10, 1'b0, 32'h3E, 32'h0, lat, e, rd);
        checks++;
        if (lat !== 1 || e !== 1'b1 || mem_r_cnt !== 0 || mem_w_cnt !== 0) begin
            failures++; $display("FAIL mis_word lat=%0d err=%b rcnt=%0d wcnt=%0d exp=1/1/0/0", lat, e, mem_r_cnt, mem_w_cnt);
        end
        checks++;
        if (rd !== 32'h0000_80FF) begin
            failures++; $display("FAIL mis_rdata_hold got=%h exp=000080ff", rd);
        end
        do_req(1'b1, 2'b01, 1'b0, 32'h41, 32'h0000_5555, lat, e, rd);
        checks++;
        if (lat !== 1 || e !== 1'b1 || mem_w_cnt !== 0 || mem_r_cnt !== 0 || mem[16] !== 32'h80FF_7F01) begin
            failures++; $display("FAIL mis_half lat=%0d err=%b wcnt=%0d mem=%h exp=1/1/0/80ff7f01", lat, e, mem_w_cnt, mem[16]);
        end
    endtask

    task automatic test_illegal_and_busy;
        int lat; logic e; logic [31:0] rd; int dones;
        do_req(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, lat, e, rd);
        checks++;
        if (lat !== 1 || e !== 1'b1 || mem_r_cnt !== 0) begin
            failures++; $display("FAIL illegal_size lat=%0d err=%b rcnt=%0d exp=1/1/0", lat, e, mem_r_cnt);
        end
        // Pulse req twice while a sub-word store is in flight.
        @(negedge CLK);
        dones = 0;
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b00; bus.sign_ext = 1'b0;
        bus.addr = 32'h44; bus.wdata = 32'h0000_0099;
        mem[17] = 32'h0;
        @(posedge CLK); #1;
        bus.req = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (bus.done) dones++;
            bus.req = (k == 1 || k == 2);
            bus.we = 1'b0; bus.addr = 32'h40; bus.size = 2'b10;
            @(posedge CLK); #1;
        end
        bus.req = 1'b0;
        checks++;
        if (dones !== 1 || mem[17] !== 32'h0000_0099 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL busy_ignore dones=%0d mem=%h busy=%b exp=1/00000099/0", dones, mem[17], bus.busy);
        end
    endtask

    task automatic test_back_to_back;
        int pos[$];
        logic idle_gap_ok;
        @(negedge CLK);
        bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'b10; bus.sign_ext = 1'b0;
        bus.addr = 32'h40;
        idle_gap_ok = 1'b1;
        @(posedge CLK); #1;
        for (int k = 1; k <= 8; k++) begin
            if (bus.done) pos.push_back(k);
            if (k == 3 && (bus.busy !== 1'b0 || bus.done !== 1'b0)) idle_gap_ok = 1'b0;
            if (k == 4) bus.req = 1'b0;
            @(posedge CLK); #1;
        end
        bus.req = 1'b0;
        checks++;
        if (pos.size() != 2 || !idle_gap_ok) begin
            failures++; $display("FAIL b2b_count dones=%0d idle_gap=%b exp=2/1", pos.size(), idle_gap_ok);
        end else begin
            checks++;
            if (pos[0] != 2 || pos[1] != 5) begin
                failures++; $display("FAIL b2b_pos got=%0d,%0d exp=2,5", pos[0], pos[1]);
            end
        end
    endtask

    task automatic test_reset_mid_rmw;
        int lat; logic e; logic [31:0] rd;
        mem[15] = 32'h1122_AB44;
        @(negedge CLK);
        mem_w_cnt = 0;
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b00; bus.sign_ext = 1'b0;
        bus.addr = 32'h3C; bus.wdata = 32'h0000_00EE;
        @(posedge CLK); #1;
        bus.req = 1'b0;
        checks++;
        if (bus.mem_R !== 1'b1) begin
            failures++; $display("FAIL mid_rmw_rd mem_R=%b exp=1", bus.mem_R);
        end
        RST_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.err, bus.mem_R, bus.mem_W} !== 5'b0 || bus.mem_Addr !== 32'h0 || bus.mem_W_data !== 32'h0) begin
            failures++; $display("FAIL mid_rst_out ctrl=%b addr=%h wdata=%h exp=0", {bus.busy, bus.done, bus.err, bus.mem_R, bus.mem_W}, bus.mem_Addr, bus.mem_W_data);
        end
        @(posedge CLK);
        @(negedge CLK);
        RST_n = 1'b1;
        checks++;
        if (mem[15] !== 32'h1122_AB44 || mem_w_cnt !== 0) begin
            failures++; $display("FAIL mid_rst_mem mem=%h wcnt=%0d exp=1122ab44/0", mem[15], mem_w_cnt);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, lat, e, rd);
        checks++;
        if (lat !== 2 || e !== 1'b0 || rd !== 32'h1122_AB44) begin
            failures++; $display("FAIL post_rst_load lat=%0d err=%b rdata=%h exp=2/0/1122ab44", lat, e, rd);
        end
    endtask

    task automatic test_exclusive;
        checks++;
        if (both_hi !== 1'b0) begin
            failures++; $display("FAIL rw_exclusive both_hi=%b exp=0", both_hi);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        mem_w_cnt = 0; mem_r_cnt = 0; both_hi = 1'b0; last_w_addr = 32'h0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
        bus.addr = 32'h0; bus.wdata = 32'h0;
        test_reset();
        test_word_store_load();
        test_byte_rmw();
        test_loads();
        test_misaligned();
        test_illegal_and_busy();
        test_back_to_back();
        test_reset_mid_rmw();
        test_exclusive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the single-port data/instruction memory interface (Addr, R, W, W_data, R_data) in the multi-cycle MIPS core.
- Accepts one CPU-side load/store request at a time, then sequences R/W to the memory.
- Byte and halfword stores use read-modify-write; loads are extracted and sign/zero-extended.
- Reports completion with a one-cycle done pulse and flags misaligned or illegal accesses without touching memory.

Parameters:
- DataWidth, 32, memory word width; fixed at 32 by the byte-lane logic.
- AddrWidth, 32, byte-address width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_n  in  1  asynchronous active-low reset.
- req  in  1  request strobe, sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  AddrWidth  byte address.
- wdata  in  32  store data, right-justified for byte/half.
- busy  out  1  high from the cycle after acceptance through the done cycle.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; misaligned or illegal size.
- rdata  out  32  load result, valid with done and held until the next acceptance.
- mem_Addr  out  AddrWidth  memory address, word-aligned (low 2 bits forced 0).
- mem_R  out  1  memory read enable.
- mem_W  out  1  memory write enable, level-sensitive at the memory.
- mem_W_data  out  32  memory write data.
- mem_R_data  in  32  memory read data; combinational from mem_Addr when mem_R=1.

Behaviour:
- Reset (async, RST_n=0): state=IDLE. busy, done, err, mem_R, mem_W = 0. rdata, mem_Addr, mem_W_data = 0.
- Reset asserted mid-operation deasserts mem_W immediately. An interrupted RMW before RMW_WR leaves memory unchanged.
- Byte lanes are little-endian: byte offset k = addr[1:0] occupies bits [8k+7:8k]. A halfword at offset 0 uses [15:0]; at offset 2 it uses [31:16].
- FSM states: IDLE, RD, WR, RMW_RD, RMW_WR, RESP, ERR. Moore outputs decoded from the registered state, so mem_W is glitch-free.
- IDLE: when req=1, latch addr/we/size/sign_ext/wdata and check legality.
  - Illegal if size=11, size=01 with addr[0]=1, or size=10 with addr[1:0]!=0.
  - Illegal -> ERR.
  - Load -> RD.
  - Word store -> WR.
  - Byte/half store -> RMW_RD.
- RD: mem_R=1. Capture mem_R_data at end of cycle, then extract the lane, extend it into rdata, and go to RESP.
- WR: mem_W=1 for exactly one cycle with stable mem_Addr/mem_W_data -> RESP.
- RMW_RD: mem_R=1. Capture the word, merge the new byte/half into the addressed lane only, and load the result into mem_W_data -> RMW_WR.
- RMW_WR: mem_W=1 for one cycle -> RESP.
- RESP: done=1, err=0 -> IDLE.
- ERR: done=1, err=1; no mem_R/mem_W asserted during the request -> IDLE. rdata is unchanged.
- Latency from the accepting edge to done: load 2 cycles, word store 2, sub-word store 3, error 1.
- req is ignored while busy. req held high through done starts a new request on the first IDLE cycle after RESP/ERR; there is no back-to-back in the done cycle.
- mem_Addr and mem_W_data change only at state entry and stay stable throughout any cycle where mem_W=1.
- mem_R and mem_W are never both 1.
- Store data uses only the low 8/16 bits of wdata for byte/half stores. Store rdata is unchanged.

Test Plan:
- Word store then load: store addr=0x3C, wdata=0x00000007, size=10 -> one mem_W pulse at mem_Addr=0x3C, done after 2 cycles. Load same -> rdata=0x00000007, err=0.
- Byte RMW: memory word 0x3C = 0x11223344; store byte 0xAB at addr 0x3D -> mem_R then mem_W, memory = 0x1122AB44, done after 3 cycles.
- Signed/unsigned loads: word at 0x40 = 0x80FF7F01.
  - byte @0x42, sign_ext=1 -> 0xFFFFFFFF.
  - byte @0x43, sign_ext=0 -> 0x00000080.
  - half @0x40, sign_ext=1 -> 0x00007F01.
- Misalignment: word load @0x3E and half store @0x41 -> done=1, err=1 after 1 cycle, no mem_R/mem_W, memory unchanged.
- Illegal size=11 -> err=1. req pulses while busy are ignored; exactly one done per accepted request.
- Reset mid-RMW: assert RST_n=0 during RMW_RD -> all outputs 0 immediately, memory word unchanged, next request completes normally.
